mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access_pkg.sv | 24 ++
 rtl/mem_access_if.sv | 22 ++
 rtl/mem_access.sv | 179 +++++++++++++++++
 tb/tb_mem_access.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared constants, state encoding and address helpers for the memory-access stage.
package mem_access_pkg;

  localparam int XLEN            = 32;
  localparam int REG_AW          = 5;
  localparam int TIMEOUT_CYC_DEF = 16;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2,
    S_ERR    = 2'd3
  } state_e;

  function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

  // Memory is word-addressed; drop the byte offset.
  function automatic logic [XLEN-1:0] word_addr(input logic [XLEN-1:0] addr);
    return {2'b00, addr[XLEN-1:2]};
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-memory request/response bus between the memory-access stage and memory.
interface mem_access_if;
  import mem_access_pkg::*;

  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_ack;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/mem_access.sv
// Memory-access pipeline stage: ALU passthrough, word load/store with ack
// handshake, misalignment and timeout error reporting.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic              ex_load_en,
  input  logic              ex_store_en,
  input  logic              ex_write_reg,
  input  logic [XLEN-1:0]   ex_res,
  input  logic [XLEN-1:0]   ex_store_data,
  input  logic [REG_AW-1:0] ex_rd,
  output logic              stall,
  mem_access_if.master      mem,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_rd,
  output logic [XLEN-1:0]   wb_data,
  output logic              err
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_e            state_q, state_d;
  logic              stall_q, stall_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              load_q, load_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wb_en_q, wb_en_d;
  logic [REG_AW-1:0] wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]   wb_data_q, wb_data_d;
  logic              err_q, err_d;

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      stall_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {XLEN{1'b0}};
      mem_wdata_q <= {XLEN{1'b0}};
      rd_q        <= {REG_AW{1'b0}};
      wr_q        <= 1'b0;
      load_q      <= 1'b0;
      rdata_q     <= {XLEN{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      wb_en_q     <= 1'b0;
      wb_rd_q     <= {REG_AW{1'b0}};
      wb_data_q   <= {XLEN{1'b0}};
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_q     <= stall_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      load_q      <= load_d;
      rdata_q     <= rdata_d;
      cnt_q       <= cnt_d;
      wb_en_q     <= wb_en_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      err_q       <= err_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    stall_d     = stall_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    load_d      = load_q;
    rdata_d     = rdata_q;
    cnt_d       = cnt_q;
    wb_en_d     = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    err_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        stall_d   = 1'b0;
        mem_req_d = 1'b0;
        if (ex_valid) begin
          if (ex_load_en || ex_store_en) begin
            if (is_word_aligned(ex_res)) begin
              state_d     = S_ACCESS;
              stall_d     = 1'b1;
              mem_req_d   = 1'b1;
              mem_we_d    = ex_store_en;
              mem_addr_d  = word_addr(ex_res);
              mem_wdata_d = ex_store_data;
              rd_d        = ex_rd;
              wr_d        = ex_write_reg;
              load_d      = ex_load_en;
              cnt_d       = {CNT_W{1'b0}};
            end else begin
              state_d = S_ERR;
              err_d   = 1'b1;
            end
          end else begin
            wb_en_d   = ex_write_reg && (ex_rd != {REG_AW{1'b0}});
            wb_rd_d   = ex_rd;
            wb_data_d = ex_res;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_ACCESS: begin
        if (mem.mem_ack) begin
          rdata_d   = mem.mem_rdata;
          state_d   = S_DONE;
          stall_d   = 1'b0;
          mem_req_d = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = S_ERR;
          stall_d   = 1'b0;
          mem_req_d = 1'b0;
          err_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        if (load_q) begin
          wb_en_d   = wr_q && (rd_q != {REG_AW{1'b0}});
          wb_rd_d   = rd_q;
          wb_data_d = rdata_q;
        end else begin
          wb_en_d = 1'b0;
        end
      end

      S_ERR: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d   = S_IDLE;
        stall_d   = 1'b0;
        mem_req_d = 1'b0;
      end
    endcase
  end

  assign stall         = stall_q;
  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign wb_en         = wb_en_q;
  assign wb_rd         = wb_rd_q;
  assign wb_data       = wb_data_q;
  assign err           = err_q;

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: expected writebacks are queued at issue
// and popped when wb_en is observed; a simple memory model answers requests.
module tb_mem_access;
  import mem_access_pkg::*;

  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ex_valid = 1'b0;
  logic              ex_load_en = 1'b0;
  logic              ex_store_en = 1'b0;
  logic              ex_write_reg = 1'b0;
  logic [XLEN-1:0]   ex_res = 32'h0;
  logic [XLEN-1:0]   ex_store_data = 32'h0;
  logic [REG_AW-1:0] ex_rd = 5'd0;
  logic              stall;
  logic              wb_en;
  logic [REG_AW-1:0] wb_rd;
  logic [XLEN-1:0]   wb_data;
  logic              err;

  mem_access_if mif();

  mem_access #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_load_en(ex_load_en),
    .ex_store_en(ex_store_en), .ex_write_reg(ex_write_reg), .ex_res(ex_res),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .stall(stall), .mem(mif),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed { logic [4:0] rd; logic [31:0] data; } wb_t;
  wb_t exp_q[$];

  int checks = 0;
  int failures = 0;

  int c0, req_seen, stall_cnt, err_cnt, err_cyc, wb_cyc, wb_count, ack_wait;
  logic stable, first_we, force_ack;
  logic [31:0] first_addr, first_wdata, ack_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic clr_stats();
    req_seen = 0; stall_cnt = 0; err_cnt = 0; err_cyc = -1;
    wb_cyc = -1; wb_count = 0; stable = 1'b1; first_we = 1'b0;
    first_addr = 32'h0; first_wdata = 32'h0; force_ack = 1'b0;
  endtask

  // One clock: sample at negedge (scoreboard, stats, memory model), return at posedge+1.
  task automatic step();
    wb_t e;
    @(negedge clk);
    if (rst_n && wb_en) begin
      wb_count++;
      wb_cyc = cyc;
      chk("wb_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
        chk("wb_data", wb_data, e.data);
      end
    end
    if (stall) stall_cnt++;
    if (err) begin
      err_cnt++;
      err_cyc = cyc - c0;
    end
    if (mif.mem_req) begin
      if (req_seen == 0) begin
        first_addr = mif.mem_addr; first_wdata = mif.mem_wdata; first_we = mif.mem_we;
      end else if (mif.mem_addr !== first_addr || mif.mem_wdata !== first_wdata ||
                   mif.mem_we !== first_we) begin
        stable = 1'b0;
      end
      if (ack_wait >= 0 && req_seen == ack_wait) begin
        mif.mem_ack = 1'b1; mif.mem_rdata = ack_data;
      end else begin
        mif.mem_ack = 1'b0;
      end
      req_seen++;
    end else begin
      mif.mem_ack = force_ack; mif.mem_rdata = ack_data;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic ld, input logic st, input logic wr, input logic [31:0] res,
                       input logic [31:0] sd, input logic [4:0] rd, input int wait_n,
                       input logic [31:0] rdata);
    int ncyc;
    clr_stats();
    ack_wait = wait_n; ack_data = rdata;
    ncyc = (wait_n < 0) ? TO + 6 : wait_n + 6;
    c0 = cyc;
    ex_valid = 1'b1; ex_load_en = ld; ex_store_en = st; ex_write_reg = wr;
    ex_res = res; ex_store_data = sd; ex_rd = rd;
    step();
    ex_valid = 1'b0; ex_load_en = 1'b0; ex_store_en = 1'b0;
    for (int k = 1; k < ncyc; k++) step();
  endtask

  initial begin
    mif.mem_ack = 1'b0; mif.mem_rdata = 32'h0; ack_wait = -1; ack_data = 32'h0;
    clr_stats();

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_req", {31'd0, mif.mem_req}, 32'd0);
    chk("rst_we", {31'd0, mif.mem_we}, 32'd0);
    chk("rst_wb_en", {31'd0, wb_en}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_addr", mif.mem_addr, 32'd0);
    chk("rst_wdata", mif.mem_wdata, 32'd0);
    chk("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ADD passthrough
    exp_q.push_back('{rd: 5'd3, data: 32'h5});
    do_op(1'b0, 1'b0, 1'b1, 32'h5, 32'h0, 5'd3, -1, 32'h0);
    chk("add_lat", wb_cyc - c0, 32'd1);
    chk("add_stall", stall_cnt, 32'd0);
    chk("add_req", req_seen, 32'd0);

    // LW, zero wait
    exp_q.push_back('{rd: 5'd7, data: 32'hDEADBEEF});
    do_op(1'b1, 1'b0, 1'b1, 32'h100, 32'h0, 5'd7, 0, 32'hDEADBEEF);
    chk("lw_req_cycles", req_seen, 32'd1);
    chk("lw_we", {31'd0, first_we}, 32'd0);
    chk("lw_addr", first_addr, 32'h40);
    chk("lw_lat", wb_cyc - c0, 32'd3);
    chk("lw_err", err_cnt, 32'd0);

    // SW, 4 wait cycles
    do_op(1'b0, 1'b1, 1'b0, 32'h20, 32'h12345678, 5'd0, 4, 32'h0);
    chk("sw_req_cycles", req_seen, 32'd5);
    chk("sw_stable", {31'd0, stable}, 32'd1);
    chk("sw_we", {31'd0, first_we}, 32'd1);
    chk("sw_addr", first_addr, 32'h8);
    chk("sw_wdata", first_wdata, 32'h12345678);
    chk("sw_stall", stall_cnt, 32'd5);
    chk("sw_wb", wb_count, 32'd0);
    chk("sw_err", err_cnt, 32'd0);

    // Misaligned LW
    do_op(1'b1, 1'b0, 1'b1, 32'h102, 32'h0, 5'd5, 0, 32'h0);
    chk("mis_req", req_seen, 32'd0);
    chk("mis_err_cnt", err_cnt, 32'd1);
    chk("mis_err_cyc", err_cyc, 32'd1);
    chk("mis_wb", wb_count, 32'd0);

    // Timeout, then a late ack
    do_op(1'b1, 1'b0, 1'b1, 32'h40, 32'h0, 5'd9, -1, 32'h0);
    chk("to_req_cycles", req_seen, 32'd16);
    chk("to_err_cnt", err_cnt, 32'd1);
    chk("to_err_cyc", err_cyc, 32'd17);
    chk("to_wb", wb_count, 32'd0);
    clr_stats();
    force_ack = 1'b1; ack_data = 32'hFFFF_0000;
    mif.mem_ack = 1'b1;
    repeat (3) step();
    force_ack = 1'b0; mif.mem_ack = 1'b0;
    step();
    chk("late_ack_req", req_seen, 32'd0);
    chk("late_ack_wb", wb_count, 32'd0);
    chk("late_ack_err", err_cnt, 32'd0);

    // ALU write to r0 never writes back
    do_op(1'b0, 1'b0, 1'b1, 32'hABCD, 32'h0, 5'd0, -1, 32'h0);
    chk("r0_wb", wb_count, 32'd0);

    // Reset asserted mid-ACCESS
    clr_stats();
    ack_wait = -1;
    c0 = cyc;
    ex_valid = 1'b1; ex_load_en = 1'b1; ex_write_reg = 1'b1; ex_res = 32'h80; ex_rd = 5'd6;
    step();
    ex_valid = 1'b0; ex_load_en = 1'b0;
    step();
    #2;
    chk("rst_mid_pre_req", {31'd0, mif.mem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_req", {31'd0, mif.mem_req}, 32'd0);
    chk("rst_mid_stall", {31'd0, stall}, 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back('{rd: 5'd4, data: 32'hA5A5_0001});
    do_op(1'b1, 1'b0, 1'b1, 32'h44, 32'h0, 5'd4, 1, 32'hA5A5_0001);
    chk("post_rst_req", req_seen, 32'd2);
    chk("post_rst_addr", first_addr, 32'h11);
    chk("post_rst_lat", wb_cyc - c0, 32'd4);
    chk("post_rst_wb", wb_count, 32'd1);

    chk("sb_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
